// File: rtl/fp8_to_fixed.sv
// FP8 (1s/3e bias 3/4m) to signed fixed point, LSB weight 2^-6.
// Iterative shifter, one bit per clock, valid/ready on both sides.
module fp8_to_fixed #(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_fp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] res,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic        sgn;
    logic [10:0] mag_r;
    logic [2:0]  cnt;

    logic [2:0]       e;
    logic [3:0]       m;
    logic [10:0]      load_mag;
    logic [2:0]       load_cnt;
    logic [OUT_W-1:0] mag_ext;
    logic [OUT_W-1:0] res_next;

    assign e = in_fp[6:4];
    assign m = in_fp[3:0];

    always_comb begin
        load_mag = {7'd0, m};
        load_cnt = 3'd0;
        if (e != 3'd0) begin
            load_mag = {6'd0, 1'b1, m};
        end
        if (e > 3'd1) begin
            load_cnt = e - 3'd1;
        end
    end

    // Negating a zero magnitude yields zero, so -0 cannot appear.
    assign mag_ext  = {{(OUT_W-11){1'b0}}, mag_r};
    assign res_next = sgn ? (~mag_ext + 1'b1) : mag_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
            mag_r     <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sgn      <= in_fp[7];
                        mag_r    <= load_mag;
                        cnt      <= load_cnt;
                        in_ready <= 1'b0;
                        state    <= (load_cnt != 3'd0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    mag_r <= mag_r << 1;
                    cnt   <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; it then holds.
                    if (!out_valid) begin
                        res       <= res_next;
                        zero      <= (mag_r == 11'd0);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_to_fixed.sv
// Directed bench for fp8_to_fixed: vector table plus
// backpressure and mid-shift reset sequences.
module tb_fp8_to_fixed;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_fp;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] res;
    logic        zero;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad = 0;

    fp8_to_fixed #(.OUT_W(12)) dut (
        .clk(clk),
        .rst(rst),
        .in_fp(in_fp),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .res(res),
        .zero(zero),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  fp;
        logic [11:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept fp, wait for out_valid, hold for `hold` cycles, then handshake.
    task automatic run_op(input logic [7:0] fp, input logic [11:0] exp_res,
                          input logic exp_zero, input int exp_lat,
                          input int hold);
        int n;
        n = 0;
        in_fp = fp;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("latency", n, exp_lat);
        check("res", int'(res), int'(exp_res));
        check("zero", int'(zero), int'(exp_zero));
        check("in_ready_done", int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_fp = 8'h55;
            step();
            check("hold_valid", int'(out_valid), 1);
            check("hold_res", int'(res), int'(exp_res));
            check("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_valid", int'(out_valid), 0);
        check("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        vecs[0]  = '{8'h15, 12'h015, 1'b0, 1};
        vecs[1]  = '{8'h24, 12'h028, 1'b0, 2};
        vecs[2]  = '{8'h0A, 12'h00A, 1'b0, 1};
        vecs[3]  = '{8'hFF, 12'h840, 1'b0, 7};
        vecs[4]  = '{8'h00, 12'h000, 1'b1, 1};
        vecs[5]  = '{8'h80, 12'h000, 1'b1, 1};
        vecs[6]  = '{8'h38, 12'h060, 1'b0, 3};
        vecs[7]  = '{8'hC1, 12'hF78, 1'b0, 4};
        vecs[8]  = '{8'h5A, 12'h1A0, 1'b0, 5};
        vecs[9]  = '{8'h8F, 12'hFF1, 1'b0, 1};
        vecs[10] = '{8'h7F, 12'h7C0, 1'b0, 7};
        vecs[11] = '{8'h9F, 12'hFE1, 1'b0, 1};

        rst = 1'b1;
        in_fp = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_res", int'(res), 0);
        check("rst_zero", int'(zero), 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].fp, vecs[i].res, vecs[i].zero, vecs[i].lat, 0);
        end

        // Backpressure with in_valid toggling during DONE.
        run_op(8'h9F, 12'hFE1, 1'b0, 1, 5);

        // Reset during the third SHIFT cycle of 0x7F.
        in_fp = 8'h7F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_res", int'(res), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        step();
        check("midrst_idle_valid", int'(out_valid), 0);
        run_op(8'h24, 12'h028, 1'b0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
